// File: rtl/div_pkg.sv
// Shared definitions for the divider pipeline wrapper.
// The wrapper is built against these types and the default operand width.
package div_pkg;

  // Default operand / result width.
  localparam int DIV_W = 32;

  // Operand-stage payload: magnitudes handed to the core plus the sign and
  // divide-by-zero bookkeeping needed to finish the result one stage later.
  typedef struct packed {
    logic [DIV_W-1:0] mag_a;
    logic [DIV_W-1:0] mag_b;
    logic [DIV_W-1:0] a_orig;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
  } div_s1_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation.
// result = neg ? -value : value, wrapping modulo 2^N (so -MIN == MIN).
module div_sign_fix
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic [N-1:0] value,
  input  logic         neg,
  output logic [N-1:0] result
);

  // Negate by invert-plus-one when requested, otherwise pass through.
  always_comb begin
    result = value;
    if (neg) begin
      result = (~value) + {{(N-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
  end

endmodule

// File: rtl/div_pipe_wrap.sv
// Two-stage signed/unsigned wrapper around an external combinational
// unsigned divider core.
//   S1: operand magnitudes + sign flags; drives core_a / core_b directly.
//   S2: sign-corrected quotient / remainder presented on the out_* port.
// Optional feature macro: DIV_ZERO_FLAG_EN. When defined, a zero divisor
// forces quotient = all ones, remainder = original dividend, out_dz = 1.
// When undefined the result is whatever the sign-corrected core returns and
// out_dz is constant 0.
module div_pipe_wrap
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_signed,
  output logic [N-1:0] core_a,
  output logic [N-1:0] core_b,
  input  logic [N-1:0] core_quo,
  input  logic [N-1:0] core_rem,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_quo,
  output logic [N-1:0] out_rem,
  output logic         out_dz
);

  // Handshake / pipeline control
  logic         s1_valid_r;
  logic         adv_s;
  logic         accept_s;

  // Operand-stage state
  logic [N-1:0] mag_a_r;
  logic [N-1:0] mag_b_r;
  logic         neg_q_r;
  logic         neg_r_r;

  // Magnitudes and sign flags derived from the incoming request
  logic [N-1:0] mag_a_s;
  logic [N-1:0] mag_b_s;
  logic         neg_a_s;
  logic         neg_b_s;

  // Sign-corrected core outputs and the value S2 will load
  logic [N-1:0] quo_fix_s;
  logic [N-1:0] rem_fix_s;
  logic [N-1:0] quo_next_s;
  logic [N-1:0] rem_next_s;

  // S1 moves into S2 when it holds data and S2 is empty or being drained.
  assign adv_s    = s1_valid_r && (!out_valid || out_ready);
  // S1 can take a new request when empty or emptying this cycle; never in reset.
  assign in_ready = !rst && (!s1_valid_r || adv_s);
  assign accept_s = in_valid && in_ready;

  // Operand sign bits only matter for two's-complement requests.
  assign neg_a_s  = in_signed && in_a[N-1];
  assign neg_b_s  = in_signed && in_b[N-1];

  // The core sees the registered magnitudes, so its result lines up with S1.
  assign core_a   = mag_a_r;
  assign core_b   = mag_b_r;

  div_sign_fix #(.N(N)) u_mag_a (
    .value  (in_a),
    .neg    (neg_a_s),
    .result (mag_a_s)
  );

  div_sign_fix #(.N(N)) u_mag_b (
    .value  (in_b),
    .neg    (neg_b_s),
    .result (mag_b_s)
  );

  div_sign_fix #(.N(N)) u_fix_quo (
    .value  (core_quo),
    .neg    (neg_q_r),
    .result (quo_fix_s)
  );

  div_sign_fix #(.N(N)) u_fix_rem (
    .value  (core_rem),
    .neg    (neg_r_r),
    .result (rem_fix_s)
  );

  // S1 occupancy: set on accept (which may coincide with advance), clear on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
    end else if (adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S1 payload: magnitudes and result sign flags captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a_r <= {N{1'b0}};
      mag_b_r <= {N{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      mag_a_r <= mag_a_s;
      mag_b_r <= mag_b_s;
      neg_q_r <= in_signed && (in_a[N-1] ^ in_b[N-1]);
      neg_r_r <= neg_a_s;
    end else begin
      mag_a_r <= mag_a_r;
      mag_b_r <= mag_b_r;
      neg_q_r <= neg_q_r;
      neg_r_r <= neg_r_r;
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic         dz_r;
  logic [N-1:0] a_orig_r;

  // Zero-divisor bookkeeping travels alongside the S1 payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_r     <= 1'b0;
      a_orig_r <= {N{1'b0}};
    end else if (accept_s) begin
      dz_r     <= (in_b == {N{1'b0}});
      a_orig_r <= in_a;
    end else begin
      dz_r     <= dz_r;
      a_orig_r <= a_orig_r;
    end
  end

  // A zero divisor overrides the core with all-ones / original dividend.
  always_comb begin
    quo_next_s = quo_fix_s;
    rem_next_s = rem_fix_s;
    if (dz_r) begin
      quo_next_s = {N{1'b1}};
      rem_next_s = a_orig_r;
    end else begin
      quo_next_s = quo_fix_s;
      rem_next_s = rem_fix_s;
    end
  end

  // Divide-by-zero flag register, loaded with the result it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_dz <= 1'b0;
    end else if (adv_s) begin
      out_dz <= dz_r;
    end else begin
      out_dz <= out_dz;
    end
  end
`else
  // Without the flag feature the sign-corrected core result is final.
  always_comb begin
    quo_next_s = quo_fix_s;
    rem_next_s = rem_fix_s;
  end

  assign out_dz = 1'b0;
`endif

  // S2 result register: load on advance, hold under back-pressure, drop when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_quo   <= {N{1'b0}};
      out_rem   <= {N{1'b0}};
    end else if (adv_s) begin
      out_valid <= 1'b1;
      out_quo   <= quo_next_s;
      out_rem   <= rem_next_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_quo   <= out_quo;
      out_rem   <= out_rem;
    end else begin
      out_valid <= out_valid;
      out_quo   <= out_quo;
      out_rem   <= out_rem;
    end
  end

endmodule

// File: tb/tb_div_pipe_wrap.sv
// Self-checking bench for div_pipe_wrap. Provides a behavioural stand-in
// for the external unsigned core (x/0 -> all ones, remainder = dividend)
// and predicts every result from plain signed/unsigned arithmetic.
module tb_div_pipe_wrap;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_signed;
  logic [N-1:0] in_a, in_b, core_a, core_b, core_quo, core_rem;
  logic         out_valid, out_ready, out_dz;
  logic [N-1:0] out_quo, out_rem;

  always #5 clk = ~clk;

  div_pipe_wrap #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_quo  (core_quo),
    .core_rem  (core_rem),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quo   (out_quo),
    .out_rem   (out_rem),
    .out_dz    (out_dz)
  );

  // External combinational unsigned divider model
  always_comb begin
    if (core_b == 32'd0) begin
      core_quo = 32'hFFFF_FFFF;
      core_rem = core_a;
    end else begin
      core_quo = core_a / core_b;
      core_rem = core_a % core_b;
    end
  end

  typedef struct packed { logic [31:0] a; logic [31:0] b; logic s; } req_t;
  typedef struct packed { logic [31:0] q; logic [31:0] r; logic dz; } res_t;

  req_t pend[$];
  res_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   consumed = 0;
  bit   acc_last;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected result straight from the arithmetic definition of division.
  function automatic res_t model(req_t r);
    res_t m;
    logic signed [31:0] sa, sb;
    sa   = r.a;
    sb   = r.b;
    m.dz = 1'b0;
    if (r.b == 32'd0) begin
`ifdef DIV_ZERO_FLAG_EN
      m.q  = 32'hFFFF_FFFF;
      m.r  = r.a;
      m.dz = 1'b1;
`else
      // core gives all ones / |a|; sign rules then apply to that
      m.q = (r.s && r.a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      m.r = r.a;
`endif
    end else if (!r.s) begin
      m.q = r.a / r.b;
      m.r = r.a % r.b;
    end else if (r.a == 32'h8000_0000 && r.b == 32'hFFFF_FFFF) begin
      m.q = 32'h8000_0000;
      m.r = 32'd0;
    end else begin
      m.q = sa / sb;
      m.r = sa % sb;
    end
    return m;
  endfunction

  // One clock: present the head request, score the handshakes that the
  // coming edge will complete, then advance to the next falling edge.
  task automatic cycle();
    res_t e;
    if (pend.size() > 0) begin
      in_valid = 1'b1; in_a = pend[0].a; in_b = pend[0].b; in_signed = pend[0].s;
    end else begin
      in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_signed = 1'b0;
    end
    #1;
    acc_last = in_valid && in_ready;
    if (out_valid && out_ready) begin
      consumed++;
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_quo", 64'(out_quo), 64'(e.q));
        chk("sb_rem", 64'(out_rem), 64'(e.r));
        chk("sb_dz",  64'(out_dz),  64'(e.dz));
      end
    end
    if (acc_last) begin
      exp_q.push_back(model(pend[0]));
      void'(pend.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(int budget, bit rand_ready);
    int n = 0;
    while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
      if (rand_ready) out_ready = ($urandom % 4) != 0;
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(pend.size() + exp_q.size()), 64'd0);
  endtask

  // Single request with fixed expected values and exact latency check.
  task automatic single(string tag, logic [31:0] a, logic [31:0] b, logic s,
                        logic [31:0] eq, logic [31:0] er, logic edz);
    out_ready = 1'b1;
    pend.push_back('{a: a, b: b, s: s});
    cycle();
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    cycle();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_quo"}, 64'(out_quo), 64'(eq));
    chk({tag, "_rem"}, 64'(out_rem), 64'(er));
    chk({tag, "_dz"},  64'(out_dz),  64'(edz));
    cycle();
    chk({tag, "_clear"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    int base;
    logic [31:0] held;
    logic [31:0] ra, rb;
    int sel;

    rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    in_a = 32'd0; in_b = 32'd0; in_signed = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_quo", 64'(out_quo), 64'd0);
    chk("rst_out_rem", 64'(out_rem), 64'd0);
    chk("rst_out_dz", 64'(out_dz), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed arithmetic cases
    single("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    single("sn100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    single("s100_n7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);
    single("min_n1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
`ifdef DIV_ZERO_FLAG_EN
    single("dz55", 32'd55, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd55, 1'b1);
`else
    single("dz55", 32'd55, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd55, 1'b0);
`endif

    // Back-pressure: four requests, consumer stalled for three cycles
    base = consumed;
    out_ready = 1'b0;
    pend.push_back('{a: 32'd1000, b: 32'd3,  s: 1'b0});
    pend.push_back('{a: 32'd77,   b: 32'd10, s: 1'b0});
    pend.push_back('{a: 32'hFFFF_FFF0, b: 32'd3, s: 1'b1});
    pend.push_back('{a: 32'd9,    b: 32'd9,  s: 1'b1});
    acc_cnt = 0;
    cycle(); acc_cnt += int'(acc_last);
    cycle(); acc_cnt += int'(acc_last);
    held = out_quo;
    cycle(); acc_cnt += int'(acc_last);
    chk("bp_accepts", 64'(acc_cnt), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_quo", 64'(out_quo), 64'(held));
    out_ready = 1'b1;
    drain(30, 1'b0);
    chk("bp_count", 64'(consumed - base), 64'd4);

    // Reset with both stages occupied
    out_ready = 1'b0;
    pend.push_back('{a: 32'd50, b: 32'd5, s: 1'b0});
    pend.push_back('{a: 32'd60, b: 32'd4, s: 1'b0});
    cycle();
    cycle();
    chk("rst_mid_s2_full", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cycle();
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    pend.delete();
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready_after", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    base = consumed;
    repeat (5) cycle();
    chk("rst_mid_no_stale", 64'(consumed - base), 64'd0);
    chk("rst_mid_idle", 64'(out_valid), 64'd0);

    // Randomised traffic with random consumer stalls
    for (int i = 0; i < 80; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom % 8;
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'd1;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = $urandom % 16;
        4: rb = 32'hFFFF_FFFF - ($urandom % 16);
        default: rb = rb;
      endcase
      pend.push_back('{a: ra, b: rb, s: 1'($urandom % 2)});
    end
    base = consumed;
    drain(1000, 1'b1);
    chk("rand_count", 64'(consumed - base), 64'd80);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div_pipe_wrap.md
DIV_PIPE_WRAP -- requirements
Module: div_pipe_wrap

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  request present.
REQ-005 The block SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 The block SHALL have ports in_a / in_b  input  N  dividend / divisor.
REQ-007 The block SHALL have port in_signed  input  1  1 = two's-complement operation, 0 = unsigned.
REQ-008 The block SHALL have ports core_a / core_b  output  N  unsigned magnitudes driven to the combinational divider core.
REQ-009 The block SHALL have ports core_quo / core_rem  input  N  unsigned quotient / remainder returned by the core in the same cycle.
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 The block SHALL have ports out_quo / out_rem  output  N  final quotient / remainder.
REQ-013 The block SHALL have port out_dz  output  1  divide-by-zero flag for the result.

Function
REQ-014 The block SHALL implement two register stages: S1 holds operand magnitudes and sign flags; S2 holds the final result.
REQ-015 core_a / core_b SHALL be driven directly from the S1 magnitude registers.
REQ-016 On accept, S1 SHALL capture the following: mag(x) = (in_signed && x[N-1]) ? -x : x for each operand; neg_q = in_signed && (in_a[N-1] ^ in_b[N-1]); neg_r = in_signed && in_a[N-1]; dz = (in_b == 0); and the original in_a.
REQ-017 The advance condition SHALL be adv = s1_valid && (!out_valid || out_ready); when adv holds, S2 SHALL load the following: out_quo = neg_q ? -core_quo : core_quo; out_rem = neg_r ? -core_rem : core_rem; out_valid = 1.
REQ-018 in_ready SHALL equal !rst && (!s1_valid || adv), giving throughput of 1 result per cycle with no bubble under continuous out_ready.
REQ-019 Latency SHALL be 2 cycles: accept at edge k yields out_valid high after edge k+1.
REQ-020 S2 SHALL hold its contents stable while out_valid && !out_ready; S1 SHALL then stall and in_ready SHALL be 0.
REQ-021 When out_ready is high, s1_valid is low and out_valid is high, out_valid SHALL clear at the next edge.
REQ-022 Simultaneous accept and advance SHALL replace the S1 contents in the same edge with no loss of data.
REQ-023 For signed MIN / -1, the result SHALL be out_quo = MIN (wrap) and out_rem = 0, with no flag.
REQ-024 All negations SHALL be modulo 2^N.

Reset
REQ-025 While rst is high at an edge, s1_valid, out_valid, out_quo, out_rem and out_dz SHALL be cleared to 0.
REQ-026 Assertion of rst mid-operation SHALL discard in-flight S1/S2 contents without producing an output.
REQ-027 in_ready SHALL be 0 during rst, and SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 When macro DIV_ZERO_FLAG_EN is defined, a dz entry SHALL produce out_quo = all ones, out_rem = original in_a, and out_dz = 1, overriding the core output.
REQ-029 When DIV_ZERO_FLAG_EN is undefined, no dz logic SHALL be present, out_dz SHALL be tied to 0, and results SHALL follow REQ-017 regardless of divisor value.

Structure
REQ-030 Shared package div_pkg SHALL hold the default-width constant DIV_W = 32 and the S1 payload struct type div_s1_t (mag_a, mag_b, a_orig, neg_q, neg_r, dz).
REQ-031 Sub-module div_sign_fix SHALL implement conditional two's-complement negation (inputs: value, neg; output: result) and SHALL be instanced four times: two magnitude instances and two correction instances.
REQ-032 The divider core SHALL remain external; the block SHALL contain no division arithmetic.

Verification
REQ-033 Scenario: unsigned, in_a = 100, in_b = 7, out_ready = 1 -> out_quo = 14, out_rem = 2, out_dz = 0, out_valid exactly 2 cycles after accept.
REQ-034 Scenario: signed, in_a = -100, in_b = 7 -> out_quo = -14, out_rem = -2; and signed in_a = 100, in_b = -7 -> out_quo = -14, out_rem = 2.
REQ-035 Scenario: signed, in_a = 0x80000000, in_b = 0xFFFFFFFF -> out_quo = 0x80000000, out_rem = 0.
REQ-036 Scenario: with DIV_ZERO_FLAG_EN, in_a = 55, in_b = 0 -> out_quo = 0xFFFFFFFF, out_rem = 55, out_dz = 1; without the macro, out_dz = 0.
REQ-037 Scenario: back-to-back 4 requests with out_ready held 0 for 3 cycles -> in_ready drops after 2 accepts, no result lost or duplicated, and the 4 results appear in order.
REQ-038 Scenario: rst asserted while S1 and S2 are both valid -> out_valid = 0 at the next edge, and no stale result appears after rst deasserts.
